// File: rtl/gemm_c_tile_drain.sv
// Drain side of the GeMM C-matrix port: buffers whole M x N tiles and serializes
// them into an element stream with per-element addresses, plus done/flush tracking.
module gemm_c_tile_drain #(
  parameter int OutDataWidth = 32,
  parameter int M            = 4,
  parameter int N            = 4,
  parameter int AddrWidth    = 16,
  parameter int Depth        = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  wr_en_i,
  input  logic [AddrWidth-1:0]                  wr_addr_i,
  input  logic [OutDataWidth*M*N-1:0]           wr_data_i,
  output logic                                  wr_ready_o,
  input  logic                                  done_i,
  output logic                                  m_valid_o,
  input  logic                                  m_ready_i,
  output logic [OutDataWidth-1:0]               m_data_o,
  output logic [AddrWidth-1:0]                  m_addr_o,
  output logic                                  m_last_o,
  output logic [$clog2(Depth+1)-1:0]            count_o,
  output logic                                  overflow_o,
  output logic                                  flush_done_o
);

  localparam int Elems = M * N;
  localparam int TileW = OutDataWidth * Elems;
  localparam int CntW  = $clog2(Depth + 1);
  localparam int PtrW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int BeatW = (Elems > 1) ? $clog2(Elems) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  logic [AddrWidth-1:0]    mem_addr [Depth];
  logic [TileW-1:0]        mem_data [Depth];
  logic [OutDataWidth-1:0] head_elems [Elems];

  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [CntW-1:0]  count;
  logic [BeatW-1:0] beat;
  state_e           state, state_next;
  logic             overflow, done_pending, flush_done;
  logic             push, pop, handshake, last_beat, eff_pending, flush_fire;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Readiness ignores a same-cycle pop, so a write while full is always dropped.
  assign wr_ready_o  = !rst_i && (count < CntW'(Depth));
  assign push        = wr_en_i && wr_ready_o;
  assign handshake   = m_valid_o && m_ready_i;
  assign last_beat   = (beat == BeatW'(Elems - 1));
  assign pop         = handshake && last_beat;
  assign eff_pending = done_pending || done_i;
  assign flush_fire  = eff_pending && (count == '0) && !push;

  // NOTE: tile storage has no reset; count/pointers alone decide which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_addr[wr_ptr] <= wr_addr_i;
      mem_data[wr_ptr] <= wr_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      beat         <= '0;
      state        <= IDLE;
      overflow     <= 1'b0;
      done_pending <= 1'b0;
      flush_done   <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
      if (handshake) beat <= last_beat ? '0 : beat + BeatW'(1);
      state <= state_next;
      if (wr_en_i && !wr_ready_o) overflow <= 1'b1;
      flush_done   <= flush_fire;
      done_pending <= eff_pending && !flush_fire;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (push) state_next = STREAM;
      STREAM: if (pop && (count == CntW'(1)) && !push) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    for (int e = 0; e < Elems; e++) begin
      head_elems[e] = mem_data[rd_ptr][e*OutDataWidth +: OutDataWidth];
    end
  end

  // Outputs are zero while idle so nothing stale leaks from unreset storage.
  always_comb begin
    m_valid_o = (state == STREAM);
    m_data_o  = '0;
    m_addr_o  = '0;
    m_last_o  = 1'b0;
    if (m_valid_o) begin
      m_data_o = head_elems[beat];
      m_addr_o = mem_addr[rd_ptr] * AddrWidth'(Elems) + AddrWidth'(beat);
      m_last_o = last_beat;
    end
  end

  assign count_o      = count;
  assign overflow_o   = overflow;
  assign flush_done_o = flush_done;

endmodule

// File: tb/tb_gemm_c_tile_drain.sv
// Scoreboard bench for gemm_c_tile_drain: stimulus pushes expected beats,
// a negedge monitor pops and compares every stream handshake.
module tb_gemm_c_tile_drain;

  localparam int OW = 32;
  localparam int M  = 4;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int D  = 2;
  localparam int E  = M * N;
  localparam int TW = OW * E;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [AW-1:0] addr;
    logic          last;
  } beat_t;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [TW-1:0] wr_data_i;
  logic          wr_ready_o;
  logic          done_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [OW-1:0] m_data_o;
  logic [AW-1:0] m_addr_o;
  logic          m_last_o;
  logic [1:0]    count_o;
  logic          overflow_o;
  logic          flush_done_o;

  gemm_c_tile_drain #(
    .OutDataWidth(OW), .M(M), .N(N), .AddrWidth(AW), .Depth(D)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o), .done_i(done_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .m_data_o(m_data_o), .m_addr_o(m_addr_o), .m_last_o(m_last_o),
    .count_o(count_o), .overflow_o(overflow_o), .flush_done_o(flush_done_o)
  );

  always #5 clk_i = ~clk_i;

  beat_t   exp_q[$];
  int      n_checks = 0;
  int      n_errors = 0;
  int      flush_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [TW-1:0] make_tile(input int base);
    logic [TW-1:0] t;
    t = '0;
    for (int e = 0; e < E; e++) t[e*OW +: OW] = OW'(base + e);
    return t;
  endfunction

  task automatic write_tile(input logic [AW-1:0] addr, input int base, input bit accept);
    beat_t b;
    wr_en_i   = 1'b1;
    wr_addr_i = addr;
    wr_data_i = make_tile(base);
    if (accept) begin
      for (int e = 0; e < E; e++) begin
        b.data = OW'(base + e);
        b.addr = AW'(int'(addr) * E + e);
        b.last = (e == E - 1);
        exp_q.push_back(b);
      end
    end
    tick();
    wr_en_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int g = 0;
    m_ready_i = 1'b1;
    while (exp_q.size() != 0 && g < 300) begin
      tick();
      g++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle"}, 64'(m_valid_o), 64'd0);
  endtask

  // Monitor: compares each handshake against the scoreboard and checks stall stability.
  logic          stall = 1'b0;
  logic [OW-1:0] prev_data;
  logic [AW-1:0] prev_addr;
  always @(negedge clk_i) begin
    beat_t b;
    if (rst_i) begin
      stall = 1'b0;
    end else begin
      if (stall && m_valid_o)
        check("stall_hold", {16'd0, m_data_o, m_addr_o}, {16'd0, prev_data, prev_addr});
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got data %0h addr %0h expected no beat", m_data_o, m_addr_o);
        end else begin
          b = exp_q.pop_front();
          check("beat_data", 64'(m_data_o), 64'(b.data));
          check("beat_addr", 64'(m_addr_o), 64'(b.addr));
          check("beat_last", 64'(m_last_o), 64'(b.last));
        end
      end
      stall     = m_valid_o && !m_ready_i;
      prev_data = m_data_o;
      prev_addr = m_addr_o;
    end
    if (flush_done_o) flush_cnt++;
  end

  initial begin
    int g;
    int fbase;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst_i = 1'b1; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    done_i = 1'b0; m_ready_i = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_valid", 64'(m_valid_o), 64'd0);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    check("rst_flush", 64'(flush_done_o), 64'd0);
    check("rst_outs", {15'd0, m_data_o, m_addr_o, m_last_o}, 64'd0);
    check("rst_wr_ready", 64'(wr_ready_o), 64'd0);
    rst_i = 1'b0;
    tick();
    check("wr_ready_after_rst", 64'(wr_ready_o), 64'd1);

    // Single tile, addr 3, elements 100..115
    m_ready_i = 1'b1;
    check("valid_before_write", 64'(m_valid_o), 64'd0);
    write_tile(16'd3, 100, 1'b1);
    check("valid_latency", 64'(m_valid_o), 64'd1);
    drain("single");

    // Same tile with ready toggling 1,0,0,1
    write_tile(16'd3, 100, 1'b1);
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      m_ready_i = pat[g % 4];
      tick();
      g++;
    end
    drain("toggle");

    // Overflow: three writes while stalled, third dropped
    m_ready_i = 1'b0;
    write_tile(16'd1, 200, 1'b1);
    write_tile(16'd2, 300, 1'b1);
    write_tile(16'd5, 900, 1'b0);
    check("full_count", 64'(count_o), 64'd2);
    check("full_wr_ready", 64'(wr_ready_o), 64'd0);
    check("overflow_set", 64'(overflow_o), 64'd1);
    tick(); tick();
    check("overflow_sticky", 64'(overflow_o), 64'd1);
    drain("overflow");
    check("overflow_sticky2", 64'(overflow_o), 64'd1);

    // Full FIFO, write coincides with last-beat handshake
    m_ready_i = 1'b0;
    write_tile(16'd1, 200, 1'b1);
    write_tile(16'd2, 300, 1'b1);
    m_ready_i = 1'b1;
    repeat (15) tick();
    check("at_last_beat", 64'(m_last_o), 64'd1);
    write_tile(16'd6, 400, 1'b0);
    check("drop_on_pop_count", 64'(count_o), 64'd1);
    // count 1, push on the last-beat pop
    repeat (15) tick();
    check("one_wr_ready", 64'(wr_ready_o), 64'd1);
    write_tile(16'd7, 500, 1'b1);
    check("push_pop_count", 64'(count_o), 64'd1);
    check("push_pop_no_gap", 64'(m_valid_o), 64'd1);
    drain("push_pop");

    // done_i with empty FIFO
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check("flush_empty_pulse", 64'(flush_done_o), 64'd1);
    tick();
    check("flush_empty_single", 64'(flush_done_o), 64'd0);

    // done_i (twice) with two tiles queued
    m_ready_i = 1'b0;
    done_i = 1'b1;
    write_tile(16'd10, 1100, 1'b1);
    done_i = 1'b1;
    write_tile(16'd11, 1200, 1'b1);
    done_i = 1'b0;
    check("queued_count", 64'(count_o), 64'd2);
    fbase = flush_cnt;
    m_ready_i = 1'b1;
    g = 0;
    while (count_o != 2'd0 && g < 100) begin
      tick();
      g++;
    end
    check("queued_emptied", 64'(count_o), 64'd0);
    check("no_early_flush", 64'(flush_done_o), 64'd0);
    check("no_early_flush_cnt", 64'(flush_cnt - fbase), 64'd0);
    tick();
    check("flush_after_drain", 64'(flush_done_o), 64'd1);
    tick();
    check("flush_drain_single", 64'(flush_done_o), 64'd0);
    tick(); tick();
    check("flush_one_pulse", 64'(flush_cnt - fbase), 64'd1);
    check("queued_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-stream at beat 7 with done pending
    m_ready_i = 1'b0;
    write_tile(16'd9, 700, 1'b1);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    m_ready_i = 1'b1;
    repeat (7) tick();
    check("pre_rst_overflow", 64'(overflow_o), 64'd1);
    m_ready_i = 1'b0;
    rst_i = 1'b1;
    exp_q.delete();
    fbase = flush_cnt;
    tick();
    rst_i = 1'b0;
    check("mid_rst_valid", 64'(m_valid_o), 64'd0);
    check("mid_rst_count", 64'(count_o), 64'd0);
    check("mid_rst_overflow", 64'(overflow_o), 64'd0);
    repeat (4) tick();
    check("mid_rst_no_flush", 64'(flush_cnt - fbase), 64'd0);

    // Address wrap from tile address 0xFFFF
    m_ready_i = 1'b1;
    write_tile(16'hFFFF, 1000, 1'b1);
    drain("wrap");
    check("wrap_no_flush", 64'(flush_cnt - fbase), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
